// File: rtl/wb_ram_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// wb_arb_pkg
// Shared types and constants for the Wishbone RAM arbiter.
//   arb_state_t    : arbiter FSM states (IDLE, BUS, DONE)
//   WB_CTI_CLASSIC : cycle type identifier for classic single transfers
//   WB_BTE_LINEAR  : burst type extension (unused by classic cycles, tied)
// ---------------------------------------------------------------------------
package wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    localparam logic [2:0] WB_CTI_CLASSIC = 3'b000;
    localparam logic [1:0] WB_BTE_LINEAR  = 2'b00;

endpackage

// File: rtl/wb_ram_arbiter_rr_picker.sv
// ---------------------------------------------------------------------------
// rr_picker
// Combinational round-robin priority selector. Searches the request vector
// starting one position after last_grant_i, wrapping around, and returns the
// first set index.
//   req_i        : request vector, one bit per requester
//   last_grant_i : index granted most recently
//   valid_o      : at least one request is set
//   grant_o      : selected requester index (0 when valid_o is low)
// ---------------------------------------------------------------------------
module rr_picker #(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [$clog2(NUM_REQ)-1:0] last_grant_i,
    output logic                       valid_o,
    output logic [$clog2(NUM_REQ)-1:0] grant_o
);

    localparam int GW = $clog2(NUM_REQ);

    int cand;

    always_comb begin
        valid_o = 1'b0;
        grant_o = '0;
        cand    = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = (int'(last_grant_i) + 1 + i) % NUM_REQ;
            if (!valid_o && req_i[cand]) begin
                valid_o = 1'b1;
                grant_o = GW'(cand);
            end
        end
    end

endmodule

// File: rtl/wb_ram_arbiter.sv
// ---------------------------------------------------------------------------
// wb_ram_arbiter
// Shares one classic-cycle Wishbone RAM master port between NUM_REQ
// requesters using round-robin arbitration; one transfer at a time.
//
// Optional build macro: WB_ARB_TIMEOUT_EN -- adds a bus watchdog that ends a
// transfer with req_err=1 after TIMEOUT_CYCLES cycles without ack/err.
//
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   req_valid/we      : per-requester strobe (held until done) and direction
//   req_adr/wdata/sel : flattened per-requester payload (30/32/4 bits each)
//   req_done          : one-hot, one-cycle completion pulse
//   req_err           : qualifies req_done (bus error or timeout)
//   req_rdata         : read data, valid with req_done, held otherwise
//   grant_id          : current or last granted requester
//   busy              : a bus transfer is outstanding
//   cfu_ram_*         : Wishbone master port
// ---------------------------------------------------------------------------
module wb_ram_arbiter
    import wb_arb_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ-1:0]         req_we,
    input  logic [30*NUM_REQ-1:0]      req_adr,
    input  logic [32*NUM_REQ-1:0]      req_wdata,
    input  logic [4*NUM_REQ-1:0]       req_sel,
    output logic [NUM_REQ-1:0]         req_done,
    output logic                       req_err,
    output logic [31:0]                req_rdata,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic [29:0]                cfu_ram_adr,
    output logic [31:0]                cfu_ram_dat_mosi,
    output logic [3:0]                 cfu_ram_sel,
    output logic                       cfu_ram_cyc,
    output logic                       cfu_ram_stb,
    output logic                       cfu_ram_we,
    output logic [2:0]                 cfu_ram_cti,
    output logic [1:0]                 cfu_ram_bte,
    input  logic [31:0]                cfu_ram_dat_miso,
    input  logic                       cfu_ram_ack,
    input  logic                       cfu_ram_err
);

    localparam int GW = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("wb_ram_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
    end

    arb_state_t     state_q, state_d;
    logic [29:0]    adr_q, adr_d;
    logic [31:0]    wdata_q, wdata_d;
    logic [3:0]     sel_q, sel_d;
    logic           we_q, we_d;
    logic [GW-1:0]  grant_q, grant_d;
    logic [GW-1:0]  last_grant_q, last_grant_d;
    logic [31:0]    rdata_q, rdata_d;
    logic           err_q, err_d;

    logic           pick_valid;
    logic [GW-1:0]  pick_idx;

`ifdef WB_ARB_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TW-1:0]  to_cnt_q, to_cnt_d;
`endif

    rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .req_i        (req_valid),
        .last_grant_i (last_grant_q),
        .valid_o      (pick_valid),
        .grant_o      (pick_idx)
    );

    always_comb begin
        state_d      = state_q;
        adr_d        = adr_q;
        wdata_d      = wdata_q;
        sel_d        = sel_q;
        we_d         = we_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
`ifdef WB_ARB_TIMEOUT_EN
        to_cnt_d     = to_cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    // Latch the winner's payload so later payload changes are ignored.
                    grant_d = pick_idx;
                    adr_d   = req_adr[30*int'(pick_idx) +: 30];
                    wdata_d = req_wdata[32*int'(pick_idx) +: 32];
                    sel_d   = req_sel[4*int'(pick_idx) +: 4];
                    we_d    = req_we[pick_idx];
                    err_d   = 1'b0;
                    state_d = BUS;
`ifdef WB_ARB_TIMEOUT_EN
                    to_cnt_d = '0;
`endif
                end
            end
            BUS: begin
                // Error takes priority over a simultaneous ack.
                if (cfu_ram_err) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else if (cfu_ram_ack) begin
                    err_d   = 1'b0;
                    if (!we_q) begin
                        rdata_d = cfu_ram_dat_miso;
                    end
                    state_d = DONE;
                end
`ifdef WB_ARB_TIMEOUT_EN
                else if (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    to_cnt_d = to_cnt_q + TW'(1);
                end
`endif
            end
            DONE: begin
                last_grant_d = grant_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            adr_q        <= '0;
            wdata_q      <= '0;
            sel_q        <= '0;
            we_q         <= 1'b0;
            grant_q      <= '0;
            // Pointing at the last index makes the first search begin at requester 0.
            last_grant_q <= GW'(NUM_REQ - 1);
            rdata_q      <= '0;
            err_q        <= 1'b0;
`ifdef WB_ARB_TIMEOUT_EN
            to_cnt_q     <= '0;
`endif
        end else begin
            state_q      <= state_d;
            adr_q        <= adr_d;
            wdata_q      <= wdata_d;
            sel_q        <= sel_d;
            we_q         <= we_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
`ifdef WB_ARB_TIMEOUT_EN
            to_cnt_q     <= to_cnt_d;
`endif
        end
    end

    assign cfu_ram_cyc      = (state_q == BUS);
    assign cfu_ram_stb      = (state_q == BUS);
    assign busy             = (state_q == BUS);
    assign cfu_ram_adr      = adr_q;
    assign cfu_ram_dat_mosi = wdata_q;
    assign cfu_ram_sel      = sel_q;
    assign cfu_ram_we       = we_q;
    assign cfu_ram_cti      = WB_CTI_CLASSIC;
    assign cfu_ram_bte      = WB_BTE_LINEAR;

    assign grant_id  = grant_q;
    assign req_rdata = rdata_q;
    assign req_done  = (state_q == DONE) ? (NUM_REQ'(1) << grant_q) : '0;
    assign req_err   = (state_q == DONE) && err_q;

endmodule

// File: tb/tb_wb_ram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wb_ram_arbiter
// Scoreboard bench for wb_ram_arbiter with two requesters and a simple
// Wishbone slave model. Build with WB_ARB_TIMEOUT_EN to exercise the watchdog.
// ---------------------------------------------------------------------------
module tb_wb_ram_arbiter;

    localparam int N = 2;
`ifdef WB_ARB_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 255;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      req_valid, req_we, req_done;
    logic [30*N-1:0]   req_adr;
    logic [32*N-1:0]   req_wdata;
    logic [4*N-1:0]    req_sel;
    logic              req_err, busy;
    logic [31:0]       req_rdata;
    logic [$clog2(N)-1:0] grant_id;
    logic [29:0]       cfu_ram_adr;
    logic [31:0]       cfu_ram_dat_mosi, cfu_ram_dat_miso;
    logic [3:0]        cfu_ram_sel;
    logic              cfu_ram_cyc, cfu_ram_stb, cfu_ram_we, cfu_ram_ack, cfu_ram_err;
    logic [2:0]        cfu_ram_cti;
    logic [1:0]        cfu_ram_bte;

    always #5 clk = ~clk;

    wb_ram_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_we(req_we), .req_adr(req_adr),
        .req_wdata(req_wdata), .req_sel(req_sel),
        .req_done(req_done), .req_err(req_err), .req_rdata(req_rdata),
        .grant_id(grant_id), .busy(busy),
        .cfu_ram_adr(cfu_ram_adr), .cfu_ram_dat_mosi(cfu_ram_dat_mosi),
        .cfu_ram_sel(cfu_ram_sel), .cfu_ram_cyc(cfu_ram_cyc),
        .cfu_ram_stb(cfu_ram_stb), .cfu_ram_we(cfu_ram_we),
        .cfu_ram_cti(cfu_ram_cti), .cfu_ram_bte(cfu_ram_bte),
        .cfu_ram_dat_miso(cfu_ram_dat_miso), .cfu_ram_ack(cfu_ram_ack),
        .cfu_ram_err(cfu_ram_err)
    );

    // Slave model: responds when cyc has been high for slv_lat previous cycles.
    logic [7:0]  slv_cnt = '0;
    int          slv_lat;
    logic        slv_ack_en, slv_err_en, inj_ack;
    logic [31:0] slv_data;

    always @(posedge clk) slv_cnt <= cfu_ram_cyc ? slv_cnt + 8'd1 : 8'd0;

    assign cfu_ram_ack      = (cfu_ram_cyc && slv_ack_en && (int'(slv_cnt) == slv_lat)) || inj_ack;
    assign cfu_ram_err      = cfu_ram_cyc && slv_err_en && (int'(slv_cnt) == slv_lat);
    assign cfu_ram_dat_miso = slv_data;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    typedef struct {
        int          idx;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   model_last = N - 1;
    int   done_cnt = 0;
    int   cyc_run = 0;
    int   cyc_len = 0;

    task automatic push(input int idx, input logic err, input logic [31:0] rdata);
        exp_t e;
        e.idx = idx; e.err = err; e.rdata = rdata;
        sb.push_back(e);
        model_last = idx;
    endtask

    // Monitor: measures cyc run lengths and scores every completion pulse.
    always @(negedge clk) begin
        if (cfu_ram_cyc) begin
            cyc_run++;
        end else if (cyc_run != 0) begin
            cyc_len = cyc_run;
            cyc_run = 0;
        end
        if (req_done != '0) begin
            check("done_onehot", 64'($onehot(req_done)), 64'd1);
            check("done_vs_grant", 64'(req_done), 64'(1 << grant_id));
            if (sb.size() == 0) begin
                check("unexpected_done", 64'(req_done), 64'd0);
            end else begin
                mon_e = sb.pop_front();
                check("grant_idx", 64'(grant_id), 64'(mon_e.idx));
                check("req_err", 64'(req_err), 64'(mon_e.err));
                check("req_rdata", 64'(req_rdata), 64'(mon_e.rdata));
            end
            done_cnt++;
        end
    end

    task automatic wait_done(input int target, input int bound);
        int n = 0;
        while (done_cnt < target && n < bound) begin
            @(negedge clk); #1;
            n++;
        end
        if (done_cnt < target) check("wait_done_timeout", 64'(done_cnt), 64'(target));
    endtask

    task automatic wait_cyc(input int bound);
        int n = 0;
        while (!cfu_ram_cyc && n < bound) begin
            @(negedge clk); #1;
            n++;
        end
        if (!cfu_ram_cyc) check("wait_cyc_timeout", 64'(cfu_ram_cyc), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_watchdog: got stuck expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nxt;
        reset = 1'b1; req_valid = '0; req_we = '0; req_adr = '0; req_wdata = '0; req_sel = '0;
        slv_ack_en = 1'b1; slv_err_en = 1'b0; inj_ack = 1'b0; slv_lat = 0; slv_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        check("rst_cyc", 64'(cfu_ram_cyc), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(req_done), 64'd0);
        check("rst_grant", 64'(grant_id), 64'd0);
        check("rst_rdata", 64'(req_rdata), 64'd0);
        check("rst_cti", 64'(cfu_ram_cti), 64'd0);
        reset = 1'b0;

        // Single read from requester 0, ack in the second bus cycle.
        @(negedge clk);
        slv_lat = 1; slv_data = 32'hDEADBEEF;
        push(0, 1'b0, 32'hDEADBEEF);
        req_adr[29:0] = 30'h100; req_we[0] = 1'b0; req_sel[3:0] = 4'hF; req_valid[0] = 1'b1;
        wait_cyc(10);
        check("rd_adr", 64'(cfu_ram_adr), 64'h100);
        check("rd_we", 64'(cfu_ram_we), 64'd0);
        wait_done(1, 20);
        req_valid[0] = 1'b0;
        check("rd_cyc_len", 64'(cyc_len), 64'd2);

        // Single write from requester 1; payload scrambled after grant.
        slv_lat = 2;
        push(1, 1'b0, 32'hDEADBEEF);
        req_adr[59:30] = 30'h2A; req_wdata[63:32] = 32'h12345678; req_sel[7:4] = 4'b0011;
        req_we[1] = 1'b1; req_valid[1] = 1'b1;
        wait_cyc(10);
        for (int i = 0; i < 10 && cfu_ram_cyc; i++) begin
            check("wr_adr", 64'(cfu_ram_adr), 64'h2A);
            check("wr_dat", 64'(cfu_ram_dat_mosi), 64'h12345678);
            check("wr_sel", 64'(cfu_ram_sel), 64'h3);
            check("wr_we", 64'(cfu_ram_we), 64'd1);
            req_adr[59:30] = '1; req_wdata[63:32] = '1; req_sel[7:4] = '1;
            @(negedge clk); #1;
        end
        wait_done(2, 20);
        req_valid[1] = 1'b0; req_we[1] = 1'b0;
        check("wr_cyc_len", 64'(cyc_len), 64'd3);

        // Contention: both request continuously for four zero-wait transfers.
        slv_lat = 0; slv_data = 32'hC0FFEE00;
        for (int k = 0; k < 4; k++) begin
            nxt = (model_last + 1) % N;
            push(nxt, 1'b0, 32'hC0FFEE00);
        end
        req_valid = 2'b11;
        wait_done(6, 40);
        req_valid = '0;

        // Bus error together with ack: error wins, read data not captured.
        slv_err_en = 1'b1; slv_data = 32'h55555555;
        push(0, 1'b1, 32'hC0FFEE00);
        req_valid[0] = 1'b1;
        wait_done(7, 20);
        req_valid[0] = 1'b0; slv_err_en = 1'b0;
        slv_data = 32'h13579BDF;
        push(1, 1'b0, 32'h13579BDF);
        req_valid[1] = 1'b1;
        wait_done(8, 20);
        req_valid[1] = 1'b0;

        // Reset while the bus is waiting for a slave that never answers.
        slv_ack_en = 1'b0;
        req_valid[1] = 1'b1;
        wait_cyc(10);
        @(negedge clk); #1;
        reset = 1'b1; req_valid = '0;
        @(negedge clk); #1;
        check("rstmid_cyc", 64'(cfu_ram_cyc), 64'd0);
        check("rstmid_stb", 64'(cfu_ram_stb), 64'd0);
        check("rstmid_busy", 64'(busy), 64'd0);
        check("rstmid_done", 64'(req_done), 64'd0);
        check("rstmid_cnt", 64'(done_cnt), 64'd8);
        reset = 1'b0;
        model_last = N - 1;
        slv_ack_en = 1'b1; slv_data = 32'h0BADF00D;
        push((model_last + 1) % N, 1'b0, 32'h0BADF00D);
        req_valid = 2'b11;
        wait_done(9, 20);
        req_valid = '0;

`ifdef WB_ARB_TIMEOUT_EN
        // Watchdog: slave never acks; a late ack must be ignored.
        slv_ack_en = 1'b0;
        push(0, 1'b1, 32'h0BADF00D);
        req_valid[0] = 1'b1;
        wait_done(10, 40);
        req_valid[0] = 1'b0;
        check("to_cyc_len", 64'(cyc_len), 64'd8);
        repeat (2) @(negedge clk);
        inj_ack = 1'b1;
        @(negedge clk);
        inj_ack = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("to_late_busy", 64'(busy), 64'd0);
        check("to_late_cnt", 64'(done_cnt), 64'd10);
        check("to_late_rdata", 64'(req_rdata), 64'h0BADF00D);
`endif

        repeat (3) @(negedge clk);
        #1;
        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
